// File: rtl/hall_call_if.sv
// Hall-call bus between the call panel / motion controller side and the hall call register.
// request and serve are single-cycle strobes; target_valid is a level that may be sampled any cycle.
interface hall_call_if #(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = 3
);
    logic                  request;
    logic [FLOOR_W-1:0]    request_floor;
    logic                  request_dir;
    logic [FLOOR_W-1:0]    car_floor;
    logic                  serve;
    logic                  serve_dir;
    logic [NUM_FLOORS-1:0] pending_up;
    logic [NUM_FLOORS-1:0] pending_down;
    logic                  target_valid;
    logic [FLOOR_W-1:0]    target_floor;
    logic                  target_dir;
    logic                  req_err;
    logic                  sweep_state;

    modport master (
        output request, request_floor, request_dir, car_floor, serve, serve_dir,
        input  pending_up, pending_down, target_valid, target_floor, target_dir,
               req_err, sweep_state
    );

    modport slave (
        input  request, request_floor, request_dir, car_floor, serve, serve_dir,
        output pending_up, pending_down, target_valid, target_floor, target_dir,
               req_err, sweep_state
    );
endinterface

// File: rtl/hall_call_register.sv
// Latches hall calls into up/down bitmaps, clears them on serve, and runs a
// two-state SCAN sweep that presents one registered target to the motion controller.
module hall_call_register #(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = 3
) (
    input  logic        clk,
    input  logic        reset,
    hall_call_if.slave  bus
);

    typedef enum logic {
        SWEEP_UP   = 1'b0,
        SWEEP_DOWN = 1'b1
    } sweep_t;

    sweep_t                state, state_n;
    logic [NUM_FLOORS-1:0] pend_up, pend_down;
    logic [NUM_FLOORS-1:0] set_up, set_down, clr_up, clr_down;
    logic                  req_bad;
    logic                  err_r;
    logic                  t_valid, t_valid_n;
    logic                  t_dir, t_dir_n;
    logic [FLOOR_W-1:0]    t_floor, t_floor_n;

    logic                  up1_hit, up2_hit, dn1_hit, dn2_hit;
    logic [FLOOR_W-1:0]    up1_f, up2_f, dn1_f, dn2_f;

    int req_i;
    int car_i;

    assign req_i = int'(bus.request_floor);
    assign car_i = int'(bus.car_floor);

    // Request decode: out-of-range floors and calls pointing off the shaft are dropped.
    always_comb begin
        req_bad  = 1'b0;
        set_up   = '0;
        set_down = '0;
        if (bus.request) begin
            if (req_i >= NUM_FLOORS ||
                (bus.request_dir && req_i == NUM_FLOORS - 1) ||
                (!bus.request_dir && req_i == 0)) begin
                req_bad = 1'b1;
            end else begin
                for (int f = 0; f < NUM_FLOORS; f++) begin
                    if (f == req_i) begin
                        if (bus.request_dir) set_up[f]   = 1'b1;
                        else                 set_down[f] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        clr_up   = '0;
        clr_down = '0;
        if (bus.serve) begin
            for (int f = 0; f < NUM_FLOORS; f++) begin
                if (f == car_i) begin
                    if (bus.serve_dir) clr_up[f]   = 1'b1;
                    else               clr_down[f] = 1'b1;
                end
            end
        end
    end

    // Set is applied after clear so a call arriving with a serve of the same bit survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_up   <= '0;
            pend_down <= '0;
            err_r     <= 1'b0;
        end else begin
            pend_up   <= (pend_up & ~clr_up) | set_up;
            pend_down <= (pend_down & ~clr_down) | set_down;
            err_r     <= req_bad;
        end
    end

    // Candidate search; loop direction picks the nearest floor in the sweep direction.
    always_comb begin
        up1_hit = 1'b0;
        up1_f   = '0;
        up2_hit = 1'b0;
        up2_f   = '0;
        dn1_hit = 1'b0;
        dn1_f   = '0;
        dn2_hit = 1'b0;
        dn2_f   = '0;
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (f >= car_i && pend_up[f]) begin
                up1_hit = 1'b1;
                up1_f   = FLOOR_W'(f);
            end
            if (f < car_i && pend_up[f]) begin
                dn2_hit = 1'b1;
                dn2_f   = FLOOR_W'(f);
            end
        end
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (f > car_i && pend_down[f]) begin
                up2_hit = 1'b1;
                up2_f   = FLOOR_W'(f);
            end
            if (f <= car_i && pend_down[f]) begin
                dn1_hit = 1'b1;
                dn1_f   = FLOOR_W'(f);
            end
        end
    end

    always_comb begin
        state_n   = state;
        t_valid_n = t_valid;
        t_floor_n = t_floor;
        t_dir_n   = t_dir;
        if (pend_up == '0 && pend_down == '0) begin
            t_valid_n = 1'b0;
        end else begin
            case (state)
                SWEEP_UP: begin
                    if (up1_hit) begin
                        t_valid_n = 1'b1;
                        t_floor_n = up1_f;
                        t_dir_n   = 1'b1;
                    end else if (up2_hit) begin
                        t_valid_n = 1'b1;
                        t_floor_n = up2_f;
                        t_dir_n   = 1'b0;
                    end else begin
                        state_n = SWEEP_DOWN;
                    end
                end
                SWEEP_DOWN: begin
                    if (dn1_hit) begin
                        t_valid_n = 1'b1;
                        t_floor_n = dn1_f;
                        t_dir_n   = 1'b0;
                    end else if (dn2_hit) begin
                        t_valid_n = 1'b1;
                        t_floor_n = dn2_f;
                        t_dir_n   = 1'b1;
                    end else begin
                        state_n = SWEEP_UP;
                    end
                end
                default: state_n = SWEEP_UP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= SWEEP_UP;
            t_valid <= 1'b0;
            t_floor <= '0;
            t_dir   <= 1'b0;
        end else begin
            state   <= state_n;
            t_valid <= t_valid_n;
            t_floor <= t_floor_n;
            t_dir   <= t_dir_n;
        end
    end

    assign bus.pending_up   = pend_up;
    assign bus.pending_down = pend_down;
    assign bus.target_valid = t_valid;
    assign bus.target_floor = t_floor;
    assign bus.target_dir   = t_dir;
    assign bus.req_err      = err_r;
    assign bus.sweep_state  = state;

endmodule
